// File: rtl/cb_bitstream_loader.sv
// cb_bitstream_loader: serialises config words MSB-first onto the CB shift chain; CB_PARITY_EN enables word parity checking
module cb_bitstream_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 26,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_word,
   input  logic              cfg_par,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              bit_in_CB,
   output logic              prgm_b,
   output logic              cb_prgm_b_in,
   output logic              cb_prgm_b,
   output logic              busy,
   output logic              done,
   output logic              parity_err
);
   localparam int WB = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [WORD_W-1:0] sreg_q, sreg_d;
   logic [WB-1:0]     wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  tcnt_q, tcnt_d;
   logic              perr_q, perr_d;
   logic              last_bit, word_end;

   assign last_bit     = tcnt_q == CNT_W'(CHAIN_LEN - 1);
   assign word_end     = wcnt_q == WB'(WORD_W - 1);
   assign cfg_ready    = (state_q == LOAD) || (state_q == SHIFT && !last_bit && word_end);
   assign bit_in_CB    = (state_q == SHIFT) && sreg_q[WORD_W-1];
   assign prgm_b       = !(state_q == LOAD || state_q == SHIFT);
   assign cb_prgm_b_in = state_q == SHIFT;
   assign cb_prgm_b    = cb_prgm_b_in;
   assign busy         = state_q != IDLE;
   assign done         = state_q == DONE;
   assign parity_err   = perr_q;

   // next-state: session control, word reload without bubbles, and bit accounting
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      wcnt_d  = wcnt_q;
      tcnt_d  = tcnt_q;
      perr_d  = perr_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            tcnt_d  = '0;
            perr_d  = 1'b0;
         end
         LOAD: if (cfg_valid) begin
            sreg_d  = cfg_word;
            wcnt_d  = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            sreg_d = sreg_q << 1;
            wcnt_d = wcnt_q + WB'(1);
            tcnt_d = tcnt_q + CNT_W'(1);
            if (last_bit) state_d = DONE;
            else if (word_end && cfg_valid) begin
               sreg_d = cfg_word;
               wcnt_d = '0;
            end else if (word_end) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
`ifdef CB_PARITY_EN
      if (cfg_valid && cfg_ready && ^{cfg_word, cfg_par}) perr_d = 1'b1;
`endif
   end

`ifndef CB_PARITY_EN
   logic unused_par;
   assign unused_par = cfg_par;
`endif

   // state registers; reset abandons any partial session
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         wcnt_q  <= '0;
         tcnt_q  <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         wcnt_q  <= wcnt_d;
         tcnt_q  <= tcnt_d;
         perr_q  <= perr_d;
      end
   end
endmodule

// File: tb/tb_cb_bitstream_loader.sv
// tb_cb_bitstream_loader: scoreboard bench for the CB bitstream loader
module tb_cb_bitstream_loader;
   logic clk = 1'b0;
   logic reset = 1'b1, start = 1'b0, cfg_par = 1'b0, cfg_valid = 1'b0;
   logic [7:0] cfg_word = '0;
   logic cfg_ready, bit_in_CB, prgm_b, cb_prgm_b_in, cb_prgm_b, busy, done, parity_err;
   int errors = 0, checks = 0;
   bit exp_bits[$];
   int q_stall[$];

   cb_bitstream_loader dut (
      .clk(clk), .reset(reset), .start(start), .cfg_word(cfg_word), .cfg_par(cfg_par),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .bit_in_CB(bit_in_CB), .prgm_b(prgm_b),
      .cb_prgm_b_in(cb_prgm_b_in), .cb_prgm_b(cb_prgm_b), .busy(busy), .done(done),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] w, input bit p, input int gap, input bit poke);
      bit ok = 0;
      for (int i = 0; i < gap; i++) begin
         start = poke && i == 0;
         step();
      end
      start = 0;
      cfg_word = w;
      cfg_par = p;
      cfg_valid = 1;
      for (int i = 0; i < 100 && !ok; i++) begin
         ok = cfg_ready;
         step();
      end
      cfg_valid = 0;
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL accept_timeout: word %0h not accepted, required accept", w);
      end
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         seen = done;
         step();
      end
      if (!seen) begin
         errors++;
         checks++;
         $display("FAIL done_timeout: done=0, required 1");
      end
   endtask

   task automatic push_stream(input int stall_exp);
      logic [25:0] s = 26'b10100101_00111100_11111111_10;
      for (int i = 25; i >= 0; i--) exp_bits.push_back(s[i]);
      q_stall.push_back(stall_exp);
   endtask

   task automatic session(input int gap, input bit poke, input bit par2, input int stall_exp);
      push_stream(stall_exp);
      start = 1;
      step();
      start = 0;
      chk("perr_clear", parity_err, 0);
      chk("load_ready", cfg_ready, 1);
      chk("load_prgm_b", prgm_b, 0);
      send(8'hA5, 0, 0, 0);
      send(8'h3C, par2, gap, poke);
`ifdef CB_PARITY_EN
      chk("perr_after_w2", parity_err, par2);
`else
      chk("perr_after_w2", parity_err, 0);
`endif
      send(8'hFF, 0, 0, 0);
      send(8'h80, 1, 0, 0);
      wait_done();
`ifdef CB_PARITY_EN
      chk("perr_held", parity_err, par2);
`else
      chk("perr_held", parity_err, 0);
`endif
      chk("idle_busy", busy, 0);
   endtask

   // monitor: pops expected bits on every enabled cycle, audits each session at done
   initial begin
      int en = 0, stall = 0;
      bit started = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_bits.delete();
            q_stall.delete();
            en = 0;
            stall = 0;
            started = 0;
         end else begin
            chk("cb_copy", cb_prgm_b, cb_prgm_b_in);
            if (cb_prgm_b_in) begin
               chk("shift_prgm_b", prgm_b, 0);
               if (exp_bits.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL bit_extra: got bit %0b, required no enabled cycle", bit_in_CB);
               end else chk($sformatf("bit%0d", en), bit_in_CB, exp_bits.pop_front());
               en++;
               started = 1;
            end else if (busy && !prgm_b && started) stall++;
            if (done) begin
               if (q_stall.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL done_extra: got done=1, required 0");
               end else chk("stall_cycles", stall, q_stall.pop_front());
               chk("enabled_cycles", en, 26);
               chk("bits_left", exp_bits.size(), 0);
               chk("done_prgm_b", prgm_b, 1);
               chk("done_shift_en", cb_prgm_b_in, 0);
               en = 0;
               stall = 0;
               started = 0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   initial begin
      repeat (2) step();
      chk("rst_ready", cfg_ready, 0);
      chk("rst_bit", bit_in_CB, 0);
      chk("rst_prgm_b", prgm_b, 1);
      chk("rst_cb_en", cb_prgm_b_in, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_perr", parity_err, 0);
      reset = 0;
      step();
      cfg_valid = 1;
      cfg_word = 8'h55;
      for (int i = 0; i < 3; i++) begin
         chk("idle_ready", cfg_ready, 0);
         chk("idle_busy_v", busy, 0);
         step();
      end
      cfg_valid = 0;
      step();
      session(0, 0, 0, 0);
      step();
      session(10, 1, 0, 3);
      step();
      session(0, 0, 1, 0);
      session(0, 0, 0, 0);
      step();
      push_stream(0);
      start = 1;
      step();
      start = 0;
      send(8'hA5, 0, 0, 0);
      send(8'h3C, 0, 0, 0);
      repeat (2) step();
      reset = 1;
      step();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_prgm_b", prgm_b, 1);
      chk("mid_rst_cb_en", cb_prgm_b_in, 0);
      chk("mid_rst_ready", cfg_ready, 0);
      reset = 0;
      step();
      session(0, 0, 0, 0);
      repeat (3) step();
      chk("final_q", q_stall.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
